// File: rtl/riscv_pkg.sv
// Shared opcode constants, forwarding encoding, FSM states and shadow-stage
// types for the hazard controller.
package riscv_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reg_write;
    logic       is_load;
  } ex_stage_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
  } wb_stage_t;

  // MEM/WB is only the fallback: the younger MEM result always wins.
  function automatic logic [1:0] fwd_src(input logic [4:0] rs,
                                         input wb_stage_t mem,
                                         input wb_stage_t wb);
    if (mem.reg_write && mem.rd != 5'd0 && mem.rd == rs) return FWD_MEM;
    if (wb.reg_write && wb.rd != 5'd0 && wb.rd == rs) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of the IF/ID instruction into the register-usage
// fields the hazard logic needs.
module hazard_decode
  import riscv_pkg::*;
(
  input  logic [31:0] id_instr,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        reg_write,
  output logic        is_load,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  logic unused_fields;
  assign unused_fields = ^{id_instr[31:25], id_instr[14:12]};

  assign rd  = id_instr[11:7];
  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    reg_write = 1'b0;
    is_load   = 1'b0;
    case (id_instr[6:0])
      OP_REG: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        reg_write = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        uses_rs1  = 1'b1;
        reg_write = 1'b1;
      end
      OP_LOAD: begin
        uses_rs1  = 1'b1;
        reg_write = 1'b1;
        is_load   = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JAL, OP_LUI, OP_AUIPC: reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes,
// memory-wait freezes and EX operand forwarding from shadow stages.
module hazard_controller
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        ex_branch_taken,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        pc_sel_branch,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_count
);

  state_t    state_q, state_d;
  ex_stage_t ex_q;
  wb_stage_t mem_q, wb_q;

  logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       lu_hazard;
  logic       enter_stall;

  hazard_decode u_decode (
    .id_instr  (id_instr),
    .uses_rs1  (id_uses_rs1),
    .uses_rs2  (id_uses_rs2),
    .reg_write (id_reg_write),
    .is_load   (id_is_load),
    .rs1       (id_rs1),
    .rs2       (id_rs2),
    .rd        (id_rd)
  );

  assign lu_hazard = id_valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                     ((id_uses_rs1 && id_rs1 == ex_q.rd) ||
                      (id_uses_rs2 && id_rs2 == ex_q.rd));

  assign fwd_a = fwd_src(ex_q.rs1, mem_q, wb_q);
  assign fwd_b = fwd_src(ex_q.rs2, mem_q, wb_q);

  // Priority: reset, then memory wait, then branch, then load-use.
  always_comb begin
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    enter_stall   = 1'b0;
    state_d       = ST_RUN;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (!mem_ready) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      state_d = ST_MEM_WAIT;
    end else if (state_q != ST_LU_STALL) begin
      if (ex_branch_taken) begin
        pc_sel_branch = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
      end else if (lu_hazard) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_flush  = 1'b1;
        enter_stall = 1'b1;
        state_d     = ST_LU_STALL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      state_q <= state_d;
      if (enter_stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (mem_ready) begin
        wb_q  <= mem_q;
        mem_q <= '{rd: ex_q.rd, reg_write: ex_q.reg_write};
        if (idex_flush || !id_valid)
          ex_q <= '0;
        else
          ex_q <= '{rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                    reg_write: id_reg_write, is_load: id_is_load};
      end
    end
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have port id_instr, input, 32, instruction held in the IF/ID register.
REQ-004 SHALL have port id_valid, input, 1, id_instr holds a real instruction.
REQ-005 SHALL have port ex_branch_taken, input, 1, branch or jump resolved taken in EX this cycle.
REQ-006 SHALL have port mem_ready, input, 1, data memory accepts or returns this cycle.
REQ-007 SHALL have port pc_en, output, 1, PC register load enable.
REQ-008 SHALL have port pc_sel_branch, output, 1, PC loads the branch target.
REQ-009 SHALL have port ifid_en, output, 1, IF/ID register load enable.
REQ-010 SHALL have port ifid_flush, output, 1, IF/ID is cleared to a NOP.
REQ-011 SHALL have port idex_flush, output, 1, ID/EX is loaded with a bubble.
REQ-012 SHALL have port fwd_a and fwd_b, output, 2 each, EX operand sources: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-013 SHALL have port stall_count, output, 16, saturating count of load-use stall cycles.

Function
REQ-014 SHALL decode the ID opcode into uses_rs1, uses_rs2, reg_write and is_load. 0110011: rs1, rs2, write. 0010011: rs1, write. 0000011: rs1, write, load. 0100011: rs1, rs2. 1100011: rs1, rs2. 1100111: rs1, write. 1101111/0110111/0010111: write only. Any other opcode: none.
REQ-015 SHALL keep shadow stages EX, MEM and WB holding rd[4:0] and reg_write; EX also holds rs1, rs2 and is_load.
REQ-016 SHALL use FSM states RUN, LU_STALL and MEM_WAIT; reset state is RUN.
REQ-017 In any state, mem_ready=0 SHALL force MEM_WAIT: pc_en=ifid_en=0, both flushes 0, shadows hold, forwarding unchanged.
REQ-018 The state SHALL leave MEM_WAIT to RUN in the first cycle with mem_ready=1; outputs then follow the RUN rules in that same cycle.
REQ-019 In RUN, if ex_branch_taken=1, the block SHALL assert pc_en=1, pc_sel_branch=1, ifid_flush=1 and idex_flush=1 for one cycle.
REQ-020 A load-use hazard SHALL be: id_valid, EX.is_load, EX.rd!=0, and (uses_rs1 with rs1==EX.rd, or uses_rs2 with rs2==EX.rd).
REQ-021 On a load-use hazard in RUN with no branch, the block SHALL set pc_en=0, ifid_en=0 and idex_flush=1, and enter LU_STALL for exactly one cycle.
REQ-022 LU_STALL SHALL return to RUN unconditionally; in that cycle pc_en=ifid_en=1.
REQ-023 ex_branch_taken SHALL take priority over a load-use hazard; mem_ready=0 SHALL take priority over both.
REQ-024 On advance (mem_ready=1), shadows SHALL shift WB<=MEM and MEM<=EX. EX SHALL take the decoded ID fields, or a bubble (reg_write=0, is_load=0) when idex_flush=1 or id_valid=0.
REQ-025 fwd_a SHALL be 10 if MEM.reg_write, MEM.rd!=0 and MEM.rd==EX.rs1. Otherwise it SHALL be 01 under the same test on WB. Otherwise 00. fwd_b SHALL use the same rule on EX.rs2.
REQ-026 All control outputs and fwd_* SHALL be combinational from the state, shadows and inputs.
REQ-027 stall_count SHALL increment once per LU_STALL entry and hold at 16'hFFFF.
REQ-028 Default outputs in RUN with no hazard SHALL be pc_en=ifid_en=1, pc_sel_branch=0, both flushes 0.

Reset
REQ-029 While rst_n=0, the block SHALL hold state=RUN, all shadow reg_write/is_load=0, all rd/rs fields=0 and stall_count=0.
REQ-030 Under reset, outputs SHALL be pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, pc_sel_branch=0, fwd_a=fwd_b=00.
REQ-031 Reset asserted mid-stall or in MEM_WAIT SHALL discard that state immediately; no pending stall survives reset.

Structure
REQ-032 Opcode constants, the forwarding encoding and the FSM state encoding SHALL live in shared package riscv_pkg.
REQ-033 Opcode decoding SHALL be one combinational sub-module, hazard_decode (id_instr -> uses_rs1, uses_rs2, reg_write, is_load, rs1, rs2, rd).

Verification
REQ-034 Scenario: lw x5,0(x1) followed by add x6,x5,x2 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_count=1; next cycle fwd_a=01.
REQ-035 Scenario: add x3,x1,x2 followed by sub x4,x3,x3 -> no stall; fwd_a=fwd_b=10.
REQ-036 Scenario: ex_branch_taken=1 in the same cycle as a load-use hazard -> pc_sel_branch=1, ifid_flush=1, idex_flush=1, pc_en=1; stall_count unchanged.
REQ-037 Scenario: mem_ready=0 for 3 cycles during a load-use stall -> all enables 0 for 3 cycles, shadows frozen; stall resolves after mem_ready=1.
REQ-038 Scenario: lw x0,0(x1) followed by add x6,x0,x0 -> no stall; fwd_a=fwd_b=00.
REQ-039 Scenario: rst_n low while in LU_STALL -> state=RUN, stall_count=0, reset outputs per REQ-030 immediately, without waiting for a clock edge.
